// File: rtl/regfile_pkg.sv
// Shared types for the one-hot-write register file.
// Holds register count, index width, clear FSM states and a one-hot test.
package regfile_pkg;

   localparam int NREG  = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   // True when exactly one bit of v is set; v & (v-1) drops the lowest one.
   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/onehot8_to_idx.sv
// Converts an 8-bit one-hot select into a 3-bit index.
// Ports: oh_i (one-hot in), idx_o (index), valid_o (input was one-hot).
module onehot8_to_idx
   import regfile_pkg::*;
(
   input  logic [7:0]       oh_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < NREG; i++) begin
         if (oh_i[i]) idx_o = IDX_W'(i);
      end
   end

   assign valid_o = is_onehot8(oh_i);

endmodule

// File: rtl/regfile8_onehot_wr.sv
// 8-entry register file written by a one-hot decoder strobe, with two
// registered read ports (write-through bypass) and a sequential clear
// engine.
// Ports: Clock, Resetn (async, active-low); Wr/WrSel/WrData write port;
// RdAddrA/B in, RdDataA/B out; Clr in, Busy/ClrDone/WrErr status out.
module regfile8_onehot_wr
   import regfile_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Wr,
   input  logic [7:0]       WrSel,
   input  logic [WIDTH-1:0] WrData,
   input  logic [IDX_W-1:0] RdAddrA,
   input  logic [IDX_W-1:0] RdAddrB,
   output logic [WIDTH-1:0] RdDataA,
   output logic [WIDTH-1:0] RdDataB,
   input  logic             Clr,
   output logic             Busy,
   output logic             ClrDone,
   output logic             WrErr
);

   clr_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [WIDTH-1:0] rda_q, rda_d;
   logic [WIDTH-1:0] rdb_q, rdb_d;
   logic             werr_q, werr_d;

   logic [IDX_W-1:0] wr_idx;
   logic             sel_ok;
   logic             wr_ok;
   logic             idle;

   onehot8_to_idx u_sel (
      .oh_i    (WrSel),
      .idx_o   (wr_idx),
      .valid_o (sel_ok)
   );

   assign idle  = (state_q == IDLE);
   assign wr_ok = Wr && idle && sel_ok;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (Clr) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NREG - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write and clear are exclusive: writes only land in IDLE.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NREG; i++) begin
         if (state_q == CLEAR && idx_q == IDX_W'(i)) begin
            regs_d[i] = '0;
         end else if (wr_ok && wr_idx == IDX_W'(i)) begin
            regs_d[i] = WrData;
         end
      end
   end

   // Reading the next-state array gives the same-edge bypass.
   assign rda_d  = regs_d[RdAddrA];
   assign rdb_d  = regs_d[RdAddrB];
   assign werr_d = Wr && (!idle || !sel_ok);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rda_q   <= '0;
         rdb_q   <= '0;
         werr_q  <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rda_q   <= rda_d;
         rdb_q   <= rdb_d;
         werr_q  <= werr_d;
         regs_q  <= regs_d;
      end
   end

   assign RdDataA = rda_q;
   assign RdDataB = rdb_q;
   assign Busy    = !idle;
   assign ClrDone = (state_q == DONE);
   assign WrErr   = werr_q;

endmodule

// File: tb/tb_regfile8_onehot_wr.sv
// Scoreboard bench for regfile8_onehot_wr.
// A reference model pushes expected outputs per edge; they are popped after it.
module tb_regfile8_onehot_wr;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       busy;
      logic       done;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] wrsel = 8'h00;
   logic [7:0] wrdata = 8'h00;
   logic [2:0] ra = 3'd0;
   logic [2:0] rb = 3'd0;
   logic       clr = 1'b0;
   logic [7:0] rda, rdb;
   logic       busy, done, werr;

   int n_chk = 0;
   int n_pass = 0;

   exp_t       sb[$];
   logic [7:0] mem [8];
   int         st = 0;
   int         idx = 0;

   regfile8_onehot_wr #(.WIDTH(8)) dut (
      .Clock   (clk),
      .Resetn  (rst_n),
      .Wr      (wr),
      .WrSel   (wrsel),
      .WrData  (wrdata),
      .RdAddrA (ra),
      .RdAddrB (rb),
      .RdDataA (rda),
      .RdDataB (rdb),
      .Clr     (clr),
      .Busy    (busy),
      .ClrDone (done),
      .WrErr   (werr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      st  = 0;
      idx = 0;
   endtask

   // Advance model by one edge using current inputs, then compare DUT.
   task automatic tick(input string tag);
      exp_t e;
      exp_t g;
      bit   oh;
      int   wi;
      int   st_n;
      oh = ($countones(wrsel) == 1);
      wi = 0;
      for (int i = 0; i < 8; i++) if (wrsel[i]) wi = i;
      e.err = wr && (st != 0 || !oh);
      if (wr && st == 0 && oh) mem[wi] = wrdata;
      st_n = st;
      if (st == 0) begin
         if (clr) begin st_n = 1; idx = 0; end
      end else if (st == 1) begin
         mem[idx] = 8'h00;
         if (idx == 7) st_n = 2;
         idx = (idx + 1) % 8;
      end else begin
         st_n = 0;
      end
      st = st_n;
      e.a    = mem[ra];
      e.b    = mem[rb];
      e.busy = (st != 0);
      e.done = (st == 2);
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check({tag, ".A"},    32'(rda),  32'(g.a));
      check({tag, ".B"},    32'(rdb),  32'(g.b));
      check({tag, ".busy"}, 32'(busy), 32'(g.busy));
      check({tag, ".done"}, 32'(done), 32'(g.done));
      check({tag, ".err"},  32'(werr), 32'(g.err));
   endtask

   task automatic read_all(input string tag);
      wr  = 1'b0;
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ra = 3'(i);
         rb = 3'(i + 4);
         tick(tag);
      end
   endtask

   task automatic fill();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr     = 1'b1;
         wrsel  = 8'(1 << i);
         wrdata = 8'((i + 1) * 8'h11);
         tick("fill");
      end
      wr = 1'b0;
   endtask

   task automatic check_zero_now(input string tag);
      check({tag, ".A"},    32'(rda),  32'h0);
      check({tag, ".B"},    32'(rdb),  32'h0);
      check({tag, ".busy"}, 32'(busy), 32'h0);
      check({tag, ".done"}, 32'(done), 32'h0);
      check({tag, ".err"},  32'(werr), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #12;
      check_zero_now("reset");
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      read_all("rd0");

      wr = 1'b1; wrsel = 8'b0000_1000; wrdata = 8'hA5;
      tick("wrA5");
      wr = 1'b0; ra = 3'd3; rb = 3'd2;
      tick("rd3");
      read_all("rdA5");

      wr = 1'b1; wrsel = 8'b0100_0000; wrdata = 8'h3C; rb = 3'd6; ra = 3'd6;
      tick("bypass");

      wr = 1'b1; wrsel = 8'b0001_0001; wrdata = 8'hFF; ra = 3'd0; rb = 3'd4;
      tick("bad2");
      wr = 1'b1; wrsel = 8'b0000_0000; wrdata = 8'hEE;
      tick("bad0");
      wr = 1'b0; wrsel = 8'b0000_0001; wrdata = 8'hDD;
      tick("wr0");
      tick("wr0b");
      read_all("rdbad");

      fill();
      read_all("rdfill");
      clr = 1'b1;
      tick("clr");
      clr = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr = (i == 2); wrsel = 8'b0000_0010; wrdata = 8'h77;
         ra = 3'd1; rb = 3'(i);
         tick("clrrun");
      end
      wr = 1'b0;
      tick("idle");
      read_all("rdclr");

      fill();
      clr = 1'b1;
      for (int i = 0; i < 12; i++) tick("clrhold");
      clr = 1'b0;
      for (int i = 0; i < 10; i++) tick("clrtail");
      read_all("rdhold");

      fill();
      ra = 3'd7; rb = 3'd5;
      clr = 1'b1;
      tick("clr2");
      clr = 1'b0;
      for (int i = 0; i < 4; i++) tick("clr2run");
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_zero_now("midrst");
      #6 rst_n = 1'b1;
      @(posedge clk);
      #1;
      read_all("rdrst");

      fill();
      clr = 1'b1;
      tick("clr3");
      clr = 1'b0;
      for (int i = 0; i < 10; i++) tick("clr3run");
      read_all("rdclr3");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
